// File: rtl/mem_lock_arbiter_pkg.sv
// Shared types and helpers for the data-memory lock arbiter.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package mem_lock_arbiter_pkg;

  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;

  // One access as presented on the data-memory port.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              wen;
  } mem_port_req_t;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  // Distance of an issue ID from the issue head, modulo 2^width.
  // Smaller means older; the subtraction makes ID wrap-around transparent.
  function automatic logic [31:0] age_of(input logic [31:0] id,
                                         input logic [31:0] head,
                                         input int unsigned width);
    logic [31:0] mask;
    mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (id - head) & mask;
  endfunction

endpackage

// File: rtl/mem_lock_arbiter_oldest_id_select.sv
// Combinational argmin over requester ages, restricted to an eligibility mask.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the caller decides when to act on the pick.
// Ports: head (age origin), ids (per-requester issue ID), elig (mask),
//        found (any eligible), idx (oldest eligible, lowest index on ties).
module oldest_id_select
  import mem_lock_arbiter_pkg::*;
#(
  parameter int N        = 2,
  parameter int ID_WIDTH = 8,
  parameter int IDX_W    = 1
) (
  input  logic [ID_WIDTH-1:0]        head,
  input  logic [N-1:0][ID_WIDTH-1:0] ids,
  input  logic [N-1:0]               elig,
  output logic                       found,
  output logic [IDX_W-1:0]           idx
);

  logic [ID_WIDTH-1:0] best_age;
  logic [ID_WIDTH-1:0] age;

  // Strict less-than while scanning upward keeps the lowest index on ties.
  always_comb begin
    found    = 1'b0;
    idx      = '0;
    best_age = '0;
    age      = '0;
    for (int i = 0; i < N; i++) begin
      if (elig[i]) begin
        age = ID_WIDTH'(age_of(32'(ids[i]), 32'(head), ID_WIDTH));
        if (!found || (age < best_age)) begin
          found    = 1'b1;
          best_age = age;
          idx      = IDX_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/mem_lock_arbiter.sv
// Locks the single data-memory port to the oldest requesting mem sub-SIC.
// Latency: request while idle -> grant next cycle; release hands over with no gap.
// Backpressure: mem_ready=0 holds the lock and suppresses grant; flush drops the lock.
// Ports: per-SIC req/issue_id/release/addr/wdata/wen in, one-hot sic_grant out;
//        mem_ready in, mem_addr/mem_wdata/mem_wen out; owner_valid/owner_idx status.
module mem_lock_arbiter
  import mem_lock_arbiter_pkg::*;
#(
  parameter int NUM_MEM_SICS = 2,
  parameter int ID_WIDTH     = 8,
  localparam int IDX_W       = (NUM_MEM_SICS > 1) ? $clog2(NUM_MEM_SICS) : 1
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  flush,
  input  logic [ID_WIDTH-1:0]                   head_issue_id,
  input  logic [NUM_MEM_SICS-1:0]               sic_req,
  input  logic [NUM_MEM_SICS-1:0][ID_WIDTH-1:0] sic_issue_id,
  input  logic [NUM_MEM_SICS-1:0]               sic_release,
  input  logic [NUM_MEM_SICS-1:0][ADDR_W-1:0]   sic_addr,
  input  logic [NUM_MEM_SICS-1:0][DATA_W-1:0]   sic_wdata,
  input  logic [NUM_MEM_SICS-1:0]               sic_wen,
  output logic [NUM_MEM_SICS-1:0]               sic_grant,
  input  logic                                  mem_ready,
  output logic [ADDR_W-1:0]                     mem_addr,
  output logic [DATA_W-1:0]                     mem_wdata,
  output logic                                  mem_wen,
  output logic                                  owner_valid,
  output logic [IDX_W-1:0]                      owner_idx
);

  arb_state_t                state;
  logic [NUM_MEM_SICS-1:0]   owner_oh;
  logic [NUM_MEM_SICS-1:0]   elig;
  logic                      owner_req;
  logic                      owner_grant;
  logic                      sel_found;
  logic [IDX_W-1:0]          sel_idx;
  mem_port_req_t             port_req;

  assign owner_valid = (state == ARB_LOCKED);
  assign owner_oh    = NUM_MEM_SICS'(1) << owner_idx;
  assign owner_req   = sic_req[owner_idx];
  assign owner_grant = owner_valid && mem_ready && owner_req && !flush;
  assign sic_grant   = owner_grant ? owner_oh : '0;

  // While locked the selector only matters on release, and the releasing
  // owner is masked out so a re-request cannot win the hand-over edge.
  assign elig = owner_valid ? (sic_req & ~owner_oh) : sic_req;

  oldest_id_select #(
    .N        (NUM_MEM_SICS),
    .ID_WIDTH (ID_WIDTH),
    .IDX_W    (IDX_W)
  ) u_select (
    .head  (head_issue_id),
    .ids   (sic_issue_id),
    .elig  (elig),
    .found (sel_found),
    .idx   (sel_idx)
  );

  // Port mux: owner's address/data whenever locked, zero when idle.
  always_comb begin
    port_req = '0;
    if (owner_valid) begin
      port_req.addr  = sic_addr[owner_idx];
      port_req.wdata = sic_wdata[owner_idx];
      port_req.wen   = owner_grant && sic_wen[owner_idx];
    end
  end

  assign mem_addr  = port_req.addr;
  assign mem_wdata = port_req.wdata;
  assign mem_wen   = port_req.wen;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ARB_IDLE;
      owner_idx <= '0;
    end else if (flush) begin
      state     <= ARB_IDLE;
      owner_idx <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (sel_found) begin
            state     <= ARB_LOCKED;
            owner_idx <= sel_idx;
          end
        end
        ARB_LOCKED: begin
          if (owner_grant && sic_release[owner_idx]) begin
            if (sel_found) begin
              owner_idx <= sel_idx;
            end else begin
              state     <= ARB_IDLE;
              owner_idx <= '0;
            end
          end else if (!owner_req) begin
            // Owner withdrew before being granted: give the port up.
            state     <= ARB_IDLE;
            owner_idx <= '0;
          end
        end
        default: begin
          state     <= ARB_IDLE;
          owner_idx <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lock_arbiter.sv
// Self-checking bench for mem_lock_arbiter: table of per-cycle vectors with a
// scoreboard queue, plus a hand-written asynchronous reset-mid-lock sequence.
module tb_mem_lock_arbiter;

  localparam int N = 2;

  logic                clk;
  logic                rst_n;
  logic                flush;
  logic [7:0]          head_issue_id;
  logic [N-1:0]        sic_req;
  logic [N-1:0][7:0]   sic_issue_id;
  logic [N-1:0]        sic_release;
  logic [N-1:0][29:0]  sic_addr;
  logic [N-1:0][31:0]  sic_wdata;
  logic [N-1:0]        sic_wen;
  logic [N-1:0]        sic_grant;
  logic                mem_ready;
  logic [29:0]         mem_addr;
  logic [31:0]         mem_wdata;
  logic                mem_wen;
  logic                owner_valid;
  logic [0:0]          owner_idx;

  mem_lock_arbiter #(.NUM_MEM_SICS(N), .ID_WIDTH(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .head_issue_id (head_issue_id),
    .sic_req       (sic_req),
    .sic_issue_id  (sic_issue_id),
    .sic_release   (sic_release),
    .sic_addr      (sic_addr),
    .sic_wdata     (sic_wdata),
    .sic_wen       (sic_wen),
    .sic_grant     (sic_grant),
    .mem_ready     (mem_ready),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wen       (mem_wen),
    .owner_valid   (owner_valid),
    .owner_idx     (owner_idx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  localparam logic [29:0] ADDR0  = 30'h0000_0100;
  localparam logic [29:0] ADDR1  = 30'h0000_0200;
  localparam logic [31:0] WDATA0 = 32'hA0A0_0000;
  localparam logic [31:0] WDATA1 = 32'hB1B1_0001;

  typedef struct {
    logic       fl;
    logic [7:0] hd;
    logic [1:0] rq;
    logic [7:0] i0;
    logic [7:0] i1;
    logic [1:0] rl;
    logic       rd;
    logic [1:0] wn;
    logic [1:0] e_grant;
    logic       e_ov;
    logic       e_idx;
    logic       e_wen;
  } vec_t;

  typedef struct {
    logic [1:0]  grant;
    logic        ov;
    logic        idx;
    logic        wen;
    logic [29:0] addr;
    logic [31:0] wdata;
  } exp_t;

  vec_t tbl[$];
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic fl, input logic [7:0] hd, input logic [1:0] rq,
                              input logic [7:0] i0, input logic [7:0] i1, input logic [1:0] rl,
                              input logic rd, input logic [1:0] wn, input logic [1:0] eg,
                              input logic eov, input logic eix, input logic ew);
    vec_t v;
    v.fl = fl; v.hd = hd; v.rq = rq; v.i0 = i0; v.i1 = i1; v.rl = rl;
    v.rd = rd; v.wn = wn; v.e_grant = eg; v.e_ov = eov; v.e_idx = eix; v.e_wen = ew;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    flush           = v.fl;
    head_issue_id   = v.hd;
    sic_req         = v.rq;
    sic_issue_id[0] = v.i0;
    sic_issue_id[1] = v.i1;
    sic_release     = v.rl;
    mem_ready       = v.rd;
    sic_wen         = v.wn;
  endtask

  initial begin
    exp_t e;
    vec_t idle_v;

    // Single request, then release back to idle.
    tbl.push_back(mk(0, 8'h00, 2'b01, 8'h05, 8'h00, 2'b00, 1, 2'b11, 2'b00, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 2'b01, 8'h05, 8'h00, 2'b01, 1, 2'b11, 2'b01, 1, 0, 1));
    tbl.push_back(mk(0, 8'h00, 2'b00, 8'h05, 8'h00, 2'b00, 1, 2'b11, 2'b00, 0, 0, 0));
    // Wrap-around age: head FE, SIC1 id FF (age 1) beats SIC0 id 01 (age 3); gapless hand-over.
    tbl.push_back(mk(0, 8'hFE, 2'b11, 8'h01, 8'hFF, 2'b00, 1, 2'b01, 2'b00, 0, 0, 0));
    tbl.push_back(mk(0, 8'hFE, 2'b11, 8'h01, 8'hFF, 2'b10, 1, 2'b01, 2'b10, 1, 1, 0));
    tbl.push_back(mk(0, 8'hFE, 2'b01, 8'h01, 8'hFF, 2'b01, 1, 2'b01, 2'b01, 1, 0, 1));
    tbl.push_back(mk(0, 8'hFE, 2'b00, 8'h01, 8'hFF, 2'b00, 1, 2'b01, 2'b00, 0, 0, 0));
    // Memory stall for 3 cycles; release asserted without grant must not release.
    tbl.push_back(mk(0, 8'h00, 2'b01, 8'h05, 8'h00, 2'b00, 1, 2'b11, 2'b00, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 2'b01, 8'h05, 8'h00, 2'b01, 0, 2'b11, 2'b00, 1, 0, 0));
    tbl.push_back(mk(0, 8'h00, 2'b01, 8'h05, 8'h00, 2'b01, 0, 2'b11, 2'b00, 1, 0, 0));
    tbl.push_back(mk(0, 8'h00, 2'b01, 8'h05, 8'h00, 2'b01, 0, 2'b11, 2'b00, 1, 0, 0));
    tbl.push_back(mk(0, 8'h00, 2'b01, 8'h05, 8'h00, 2'b01, 1, 2'b11, 2'b01, 1, 0, 1));
    tbl.push_back(mk(0, 8'h00, 2'b00, 8'h05, 8'h00, 2'b00, 1, 2'b11, 2'b00, 0, 0, 0));
    // Abort: SIC0 (older) drops request before grant; SIC1 locks a cycle later.
    tbl.push_back(mk(0, 8'h00, 2'b11, 8'h02, 8'h05, 2'b00, 1, 2'b11, 2'b00, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 2'b10, 8'h02, 8'h05, 2'b00, 1, 2'b11, 2'b00, 1, 0, 0));
    tbl.push_back(mk(0, 8'h00, 2'b10, 8'h02, 8'h05, 2'b00, 1, 2'b11, 2'b00, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 2'b10, 8'h02, 8'h05, 2'b10, 1, 2'b11, 2'b10, 1, 1, 1));
    tbl.push_back(mk(0, 8'h00, 2'b00, 8'h02, 8'h05, 2'b00, 1, 2'b11, 2'b00, 0, 0, 0));
    // Flush while SIC1 is locked and granted.
    tbl.push_back(mk(0, 8'h00, 2'b10, 8'h02, 8'h05, 2'b00, 1, 2'b11, 2'b00, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 2'b10, 8'h02, 8'h05, 2'b00, 1, 2'b11, 2'b10, 1, 1, 1));
    tbl.push_back(mk(1, 8'h00, 2'b10, 8'h02, 8'h05, 2'b00, 1, 2'b11, 2'b00, 1, 1, 0));
    tbl.push_back(mk(0, 8'h00, 2'b00, 8'h02, 8'h05, 2'b00, 1, 2'b11, 2'b00, 0, 0, 0));
    // No preemption by an older arrival; non-owner release ignored.
    tbl.push_back(mk(0, 8'h00, 2'b01, 8'h10, 8'h01, 2'b00, 1, 2'b11, 2'b00, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 2'b11, 8'h10, 8'h01, 2'b10, 1, 2'b11, 2'b01, 1, 0, 1));
    tbl.push_back(mk(0, 8'h00, 2'b11, 8'h10, 8'h01, 2'b01, 1, 2'b11, 2'b01, 1, 0, 1));
    tbl.push_back(mk(0, 8'h00, 2'b10, 8'h10, 8'h01, 2'b10, 1, 2'b11, 2'b10, 1, 1, 1));
    tbl.push_back(mk(0, 8'h00, 2'b00, 8'h10, 8'h01, 2'b00, 1, 2'b11, 2'b00, 0, 0, 0));
    // Same SIC re-requesting after release loses the edge, re-locks via idle.
    tbl.push_back(mk(0, 8'h00, 2'b01, 8'h05, 8'h00, 2'b00, 1, 2'b11, 2'b00, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 2'b01, 8'h05, 8'h00, 2'b01, 1, 2'b11, 2'b01, 1, 0, 1));
    tbl.push_back(mk(0, 8'h00, 2'b01, 8'h05, 8'h00, 2'b00, 1, 2'b11, 2'b00, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 2'b01, 8'h05, 8'h00, 2'b01, 1, 2'b11, 2'b01, 1, 0, 1));
    tbl.push_back(mk(0, 8'h00, 2'b00, 8'h05, 8'h00, 2'b00, 1, 2'b11, 2'b00, 0, 0, 0));
    // Equal ages: lowest index first.
    tbl.push_back(mk(0, 8'h00, 2'b11, 8'h07, 8'h07, 2'b00, 1, 2'b11, 2'b00, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 2'b11, 8'h07, 8'h07, 2'b01, 1, 2'b11, 2'b01, 1, 0, 1));
    tbl.push_back(mk(0, 8'h00, 2'b10, 8'h07, 8'h07, 2'b10, 1, 2'b11, 2'b10, 1, 1, 1));
    tbl.push_back(mk(0, 8'h00, 2'b00, 8'h07, 8'h07, 2'b00, 1, 2'b11, 2'b00, 0, 0, 0));
    // Flush in idle blocks the lock.
    tbl.push_back(mk(1, 8'h00, 2'b01, 8'h05, 8'h00, 2'b00, 1, 2'b11, 2'b00, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 2'b00, 8'h05, 8'h00, 2'b00, 1, 2'b11, 2'b00, 0, 0, 0));

    idle_v = mk(0, 8'h00, 2'b00, 8'h00, 8'h00, 2'b00, 1, 2'b00, 2'b00, 0, 0, 0);
    sic_addr[0]  = ADDR0;
    sic_addr[1]  = ADDR1;
    sic_wdata[0] = WDATA0;
    sic_wdata[1] = WDATA1;
    drive(idle_v);
    rst_n = 1'b0;
    #1;
    chk("reset_grant", 32'(sic_grant), 32'h0);
    chk("reset_ov", 32'(owner_valid), 32'h0);
    chk("reset_idx", 32'(owner_idx), 32'h0);
    chk("reset_wen", 32'(mem_wen), 32'h0);
    chk("reset_addr", 32'(mem_addr), 32'h0);
    chk("reset_wdata", mem_wdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[k]) begin
      @(negedge clk);
      drive(tbl[k]);
      e.grant = tbl[k].e_grant;
      e.ov    = tbl[k].e_ov;
      e.idx   = tbl[k].e_idx;
      e.wen   = tbl[k].e_wen;
      e.addr  = !tbl[k].e_ov ? 30'h0 : (tbl[k].e_idx ? ADDR1 : ADDR0);
      e.wdata = !tbl[k].e_ov ? 32'h0 : (tbl[k].e_idx ? WDATA1 : WDATA0);
      exp_q.push_back(e);
      #1;
      e = exp_q.pop_front();
      chk($sformatf("v%0d_grant", k), 32'(sic_grant), 32'(e.grant));
      chk($sformatf("v%0d_ov", k), 32'(owner_valid), 32'(e.ov));
      chk($sformatf("v%0d_idx", k), 32'(owner_idx), 32'(e.idx));
      chk($sformatf("v%0d_wen", k), 32'(mem_wen), 32'(e.wen));
      chk($sformatf("v%0d_addr", k), 32'(mem_addr), 32'(e.addr));
      chk($sformatf("v%0d_wdata", k), mem_wdata, e.wdata);
    end

    // Asynchronous reset in the middle of a granted lock.
    @(negedge clk);
    drive(mk(0, 8'h00, 2'b01, 8'h05, 8'h00, 2'b00, 1, 2'b11, 2'b00, 0, 0, 0));
    @(posedge clk);
    #2;
    chk("prerst_grant", 32'(sic_grant), 32'h1);
    chk("prerst_ov", 32'(owner_valid), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("midrst_grant", 32'(sic_grant), 32'h0);
    chk("midrst_ov", 32'(owner_valid), 32'h0);
    chk("midrst_wen", 32'(mem_wen), 32'h0);
    chk("midrst_addr", 32'(mem_addr), 32'h0);
    chk("midrst_wdata", mem_wdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("postrst_idle_ov", 32'(owner_valid), 32'h0);
    chk("postrst_idle_grant", 32'(sic_grant), 32'h0);
    @(posedge clk);
    #1;
    chk("postrst_ov", 32'(owner_valid), 32'h1);
    chk("postrst_grant", 32'(sic_grant), 32'h1);
    chk("postrst_wen", 32'(mem_wen), 32'h1);
    chk("postrst_addr", 32'(mem_addr), 32'(ADDR0));
    @(negedge clk);
    drive(idle_v);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_lock_arbiter.md
# mem_lock_arbiter

Arbitrates the single data-memory port among `NUM_MEM_SICS` mem sub-SICs. Each sub-SIC raises a lock request tagged with its instruction's issue ID. The arbiter locks the port to the oldest requester (age measured from the issue head, so IDs may wrap). It grants accesses while memory is ready, muxes the owner's address, write data and write enable onto the port, and re-arbitrates on release. It sits between the mem sub-SICs and the data memory, next to the RF/ECR arbitration.

## Interface
Parameters:
- `NUM_MEM_SICS`, 2, number of mem requesters (1..8)
- `ID_WIDTH`, 8, issue-ID width

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous active-low reset
- `flush`  in  1  pipeline flush; drops the current lock
- `head_issue_id`  in  ID_WIDTH  oldest outstanding issue ID (age origin)
- `sic_req`  in  NUM_MEM_SICS  per-SIC lock request
- `sic_issue_id`  in  NUM_MEM_SICS×ID_WIDTH  per-SIC request issue ID
- `sic_release`  in  NUM_MEM_SICS  per-SIC release_lock
- `sic_addr`  in  NUM_MEM_SICS×30  word address
- `sic_wdata`  in  NUM_MEM_SICS×32  write data
- `sic_wen`  in  NUM_MEM_SICS  write enable
- `sic_grant`  out  NUM_MEM_SICS  one-hot access grant
- `mem_ready`  in  1  memory can accept an access this cycle
- `mem_addr`  out  30  port word address
- `mem_wdata`  out  32  port write data
- `mem_wen`  out  1  port write enable
- `owner_valid`  out  1  port locked
- `owner_idx`  out  $clog2(NUM_MEM_SICS) (min 1)  lock owner

## Operation
- Two states: IDLE (`owner_valid=0`) and LOCKED (`owner_valid=1`, `owner_idx` registered).
- Age of requester i = `(sic_issue_id[i] - head_issue_id) mod 2^ID_WIDTH`, unsigned.
- Winner = requester with the smallest age among eligible requesters. Ties go to the lowest index.
- IDLE:
  - Eligible = `sic_req`.
  - If any requester is eligible, go to LOCKED with `owner_idx` = winner at the next edge.
  - No grant is issued in the IDLE cycle.
- LOCKED, combinational outputs:
  - `sic_grant[owner] = mem_ready && sic_req[owner] && !flush`.
  - `mem_addr`, `mem_wdata` = the owner's inputs.
  - `mem_wen = sic_grant[owner] && sic_wen[owner]`.
- LOCKED, at the edge:
  - Release (`sic_release[owner] && sic_grant[owner]`): re-arbitrate with eligible = `sic_req & ~onehot(owner)`. Go to LOCKED(winner), or to IDLE if none is eligible.
  - Abort (`!sic_req[owner]` with no release): go to IDLE. No grant was issued.
  - `!mem_ready`: hold the lock. Grant stays 0.
- A `sic_release` from any non-owner is ignored.
- `flush` in any state: go to IDLE at the next edge. All grants and `mem_wen` are 0 in the flush cycle.
- In IDLE, `mem_addr`, `mem_wdata` and `mem_wen` are 0.

## Timing
- Reset values: `sic_grant=0`, `mem_wen=0`, `mem_addr=0`, `mem_wdata=0`, `owner_valid=0`, `owner_idx=0`. State is IDLE.
- First access: request in cycle t while IDLE → lock at edge t → grant in t+1 (if `mem_ready`). Latency is 1 cycle.
- Back-to-back: a release in cycle t hands the lock straight to the next winner, which is granted in t+1. Sustained throughput is 1 access/cycle with 2 or more requesters.
- The same SIC re-requesting after its own release loses that re-arbitration edge. If no other requester exists, it re-locks from IDLE one cycle later.
- The lock is not preempted: an older request arriving during LOCKED waits for release or abort.
- Wrap-around: with `head_issue_id=0xFE`, ID 0x01 (age 3) is younger than 0xFF (age 1).
- `rst_n` asserted mid-lock forces all outputs to their reset values immediately (asynchronous).

## Structure
- A shared package holds `mem_port_req_t {addr[29:0], wdata[31:0], wen}` and an `age_of(id, head)` function.
- One sub-module, `oldest_id_select`, does the combinational argmin over ages with a mask input. It is reused for both the IDLE pick and the re-arbitration on release.
- The top level holds the state register, the owner register and the output mux.

## Test plan
- Single request: SIC0 req, id 0x05, head 0x00, `mem_ready=1` → lock at edge 1; `sic_grant=01` in cycle 2; `mem_addr`/`mem_wen` follow SIC0; release → IDLE.
- Age priority with wrap: head 0xFE; SIC0 id 0x01, SIC1 id 0xFF, both request together → SIC1 granted first. On its release, SIC0 is granted the next cycle, with no idle cycle between.
- Memory stall: owner locked, `mem_ready=0` for 3 cycles → `sic_grant=0` and `mem_wen=0` for those 3 cycles; grant in the cycle `mem_ready` returns to 1.
- Abort: owner drops `sic_req` before any grant → IDLE at the next edge; a pending SIC1 request locks one cycle later.
- Flush while SIC1 is locked and granted → grant and `mem_wen` are 0 in the flush cycle; `owner_valid=0` after the edge.
- Reset mid-lock: assert `rst_n=0` asynchronously → all outputs 0 immediately; a request after reset is granted per the first-access latency.
